// File: rtl/i2c_pkg.sv
// Shared sizing constants for the I2C block's FIFOs.
package i2c_pkg;

    localparam int I2C_FIFO_DEPTH = 16;
    localparam int I2C_TX_DW      = 10;  // 8 data bits plus start and stop flags
    localparam int I2C_RX_DW      = 8;

endpackage

// File: rtl/i2c_fifo_mem.sv
// Storage array for i2c_fifo: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module i2c_fifo_mem
    import i2c_pkg::*;
#(
    parameter int DW    = I2C_RX_DW,
    parameter int DEPTH = I2C_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdat_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdat_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // write port: data lands at the write pointer on a push edge
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdat_i;
        end
    end

    assign rdat_o = mem_q[raddr_i];

endmodule

// File: rtl/i2c_fifo.sv
// First-word-fall-through FIFO with occupancy, sticky over/underflow
// flags and an optional registered watermark.
// Build option: define I2C_FIFO_THR_EN to build the watermark logic;
// otherwise thr is ignored and thr_hit is tied low.
module i2c_fifo
    import i2c_pkg::*;
#(
    parameter int DW    = I2C_RX_DW,
    parameter int DEPTH = I2C_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          wr,
    input  logic [DW-1:0] wdat,
    input  logic          rd,
    output logic [DW-1:0] rdat,
    output logic [AW:0]   ocy,
    output logic          full,
    output logic          empty,
    input  logic [AW:0]   thr,
    output logic          thr_hit,
    output logic          ovf,
    output logic          udf,
    input  logic          err_clr
);

    localparam logic [AW:0] OCY_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   ocy_q, ocy_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          push, pop;
    logic [DW-1:0] mem_rdat;

    assign full  = (ocy_q == OCY_FULL);
    assign empty = (ocy_q == '0);
    assign ocy   = ocy_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

    // a simultaneous pop frees the slot, so a push at full still goes ahead
    assign push = wr & (~full | rd);
    assign pop  = rd & ~empty;

    // next pointers and occupancy; flush overrides any push or pop
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ocy_d  = ocy_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            ocy_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            ocy_d = ocy_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // sticky errors: a new event beats err_clr; flush leaves them alone
    always_comb begin
        ovf_d = (wr & full & ~rd) | (ovf_q & ~err_clr);
        udf_d = (rd & empty)      | (udf_q & ~err_clr);
    end

    // pointer, occupancy and error state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ocy_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ocy_q  <= ocy_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

`ifdef I2C_FIFO_THR_EN
    logic thr_hit_q, thr_hit_d;

    // compared against next occupancy so the flag moves with ocy
    always_comb begin
        thr_hit_d = (thr != '0) && (ocy_d >= thr);
    end

    // watermark register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) thr_hit_q <= 1'b0;
        else       thr_hit_q <= thr_hit_d;
    end

    assign thr_hit = thr_hit_q;
`else
    logic unused_thr;
    assign unused_thr = ^thr;
    assign thr_hit    = 1'b0;
`endif

    i2c_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push & ~flush),
        .waddr_i (wptr_q),
        .wdat_i  (wdat),
        .raddr_i (rptr_q),
        .rdat_o  (mem_rdat)
    );

    // head entry only while something is stored
    assign rdat = empty ? '0 : mem_rdat;

endmodule

// File: tb/tb_i2c_fifo.sv
// Randomised and directed bench for i2c_fifo against a queue model.
module tb_i2c_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic          wr;
    logic [DW-1:0] wdat;
    logic          rd;
    logic [DW-1:0] rdat;
    logic [AW:0]   ocy;
    logic          full;
    logic          empty;
    logic [AW:0]   thr;
    logic          thr_hit;
    logic          ovf;
    logic          udf;
    logic          err_clr;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf;
    bit            m_udf;
    bit            m_thr;

    always #5 clk = ~clk;

    i2c_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .wr      (wr),
        .wdat    (wdat),
        .rd      (rd),
        .rdat    (rdat),
        .ocy     (ocy),
        .full    (full),
        .empty   (empty),
        .thr     (thr),
        .thr_hit (thr_hit),
        .ovf     (ovf),
        .udf     (udf),
        .err_clr (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit exp_thr_hit(input int sz, input int t);
`ifdef I2C_FIFO_THR_EN
        return (t != 0) && (sz >= t);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all();
        check("rdat",    rdat,    (mq.size() != 0) ? mq[0] : 8'h00);
        check("ocy",     ocy,     mq.size());
        check("full",    full,    mq.size() == DEPTH);
        check("empty",   empty,   mq.size() == 0);
        check("ovf",     ovf,     m_ovf);
        check("udf",     udf,     m_udf);
        check("thr_hit", thr_hit, m_thr);
    endtask

    // one clock: drive, advance model on the edge, then compare
    task automatic step(input bit f, input bit w, input logic [DW-1:0] d,
                        input bit r, input bit c);
        int  sz;
        bit  was_full, was_empty;
        flush = f; wr = w; wdat = d; rd = r; err_clr = c;
        @(posedge clk);
        cyc++;
        sz        = mq.size();
        was_full  = (sz == DEPTH);
        was_empty = (sz == 0);
        if (f) begin
            mq.delete();
        end else begin
            if (r && !was_empty) void'(mq.pop_front());
            if (w && (!was_full || r)) mq.push_back(d);
        end
        if (w && was_full && !r) m_ovf = 1'b1;
        else if (c)              m_ovf = 1'b0;
        if (r && was_empty)      m_udf = 1'b1;
        else if (c)              m_udf = 1'b0;
        m_thr = exp_thr_hit(mq.size(), int'(thr));
        #1;
        check_all();
        flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_thr = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] got;
        rstn = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
        wdat = '0; thr = '0;
        model_reset();
        #3;
        check_all();
        #10 rstn = 1'b1;
        @(posedge clk); #1;

        // fill 0x01..0x10
        for (int i = 1; i <= DEPTH; i++) step(0, 1, 8'(i), 0, 0);
        check("fill_full", full, 1);
        check("fill_ocy", ocy, 16);

        // overflow then clear
        step(0, 1, 8'hAA, 0, 0);
        check("ovf_set", ovf, 1);
        step(0, 0, 8'h00, 0, 1);
        check("ovf_clr", ovf, 0);

        // drain in order; 0xAA must never appear
        for (int i = 1; i <= DEPTH; i++) begin
            got = rdat;
            check("drain_order", got, i);
            step(0, 0, 8'h00, 1, 0);
        end
        check("drain_empty", empty, 1);

        // simultaneous wr/rd at full
        for (int i = 1; i <= DEPTH; i++) step(0, 1, 8'(i), 0, 0);
        step(0, 1, 8'h55, 1, 0);
        check("wrrd_full_ocy", ocy, 16);
        check("wrrd_full_ovf", ovf, 0);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 8'h00, 1, 0);
        check("wrrd_full_55", rdat, 8'h55);
        step(0, 0, 8'h00, 1, 0);

        // simultaneous wr/rd at empty
        step(0, 1, 8'h3C, 1, 0);
        check("wrrd_empty_udf", udf, 1);
        check("wrrd_empty_ocy", ocy, 1);
        check("wrrd_empty_rdat", rdat, 8'h3C);
        step(1, 0, 8'h00, 0, 1);

        // watermark at 4
        thr = 5'd4;
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hB0 + i), 0, 0);
        check("thr_below", thr_hit, 0);
        step(0, 1, 8'hB3, 0, 0);
        check("thr_at4", thr_hit, exp_thr_hit(4, 4));
        step(0, 0, 8'h00, 1, 0);
        check("thr_fall", thr_hit, 0);
        thr = 5'd17;
        for (int i = 0; i < 13; i++) step(0, 1, 8'(i), 0, 0);
        check("thr_above_depth", thr_hit, 0);
        step(1, 0, 8'h00, 0, 0);

        // flush with concurrent write at ocy 9
        thr = 5'd0;
        for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h90 + i), 0, 0);
        check("pre_flush_ocy", ocy, 9);
        step(1, 1, 8'hEE, 0, 0);
        check("flush_ocy", ocy, 0);
        check("flush_empty", empty, 1);
        step(0, 1, 8'h11, 0, 0);
        check("post_flush_head", rdat, 8'h11);

        // random traffic, write-biased then read-biased
        for (int n = 0; n < 600; n++) begin
            bit f, w, r, c;
            if ($urandom_range(0, 19) == 0) thr = 5'($urandom_range(0, 20));
            f = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 11) == 0);
            if (n < 300) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 2) == 0);
            end else begin
                w = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(f, w, 8'($urandom), r, c);
        end

        // asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hC0 + i), 0, 0);
        step(0, 0, 8'h00, 1, 0);
        #3 rstn = 1'b0;
        model_reset();
        #1;
        check_all();
        #8 rstn = 1'b1;
        @(posedge clk); #1;
        step(0, 1, 8'h77, 0, 0);
        step(0, 0, 8'h00, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
